// File: rtl/bram_mem_initiator.sv
// bram_mem_initiator: core-side load/store requester for a single-cycle-latency BRAM port, doing read-modify-write for sub-word stores.
// Optional load/store counters are built only when BRAM_INIT_STATS_EN is defined.
module bram_mem_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [BE_WIDTH-1:0]   req_byte_en,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  bram_write_enable,
  output logic [ADDR_WIDTH-1:0] bram_address,
  output logic [DATA_WIDTH-1:0] bram_write_data,
  input  logic [DATA_WIDTH-1:0] bram_read_data,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, RMW_ADDR, RMW_DATA, RMW_WR, WR, RESP} state_t;
  state_t                state_q;
  logic                  req_ready_q, resp_valid_q, we_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q, bram_wdata_q, wdata_q, merged_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic                  accept, full_store, null_store;
  assign accept     = req_valid & req_ready_q;
  assign full_store = &req_byte_en;
  assign null_store = ~|req_byte_en;
  // Enabled lanes take the latched store data, the rest keep the word just read back.
  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_merge
    assign merged_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : bram_read_data[8*i +: 8];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      we_q         <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          req_ready_q <= 1'b0;
          bram_addr_q <= req_address;
          wdata_q     <= req_wdata;
          be_q        <= req_byte_en;
          if (!req_write) state_q <= RD_ADDR;
          else if (full_store | null_store) begin
            bram_wdata_q <= req_wdata;
            we_q         <= ~null_store;
            state_q      <= WR;
          end else state_q <= RMW_ADDR;
        end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          resp_rdata_q <= bram_read_data;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RMW_ADDR: state_q <= RMW_DATA;
        RMW_DATA: begin
          bram_wdata_q <= merged_d;
          we_q         <= 1'b1;
          state_q      <= RMW_WR;
        end
        RMW_WR, WR: begin
          we_q         <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
          state_q      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end
  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign bram_write_enable = we_q;
  assign bram_address      = bram_addr_q;
  assign bram_write_data   = bram_wdata_q;
`ifdef BRAM_INIT_STATS_EN
  logic [31:0] reads_q, writes_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reads_q  <= '0;
      writes_q <= '0;
    end else if (accept) begin
      if (req_write) writes_q <= writes_q + 32'd1;
      else reads_q <= reads_q + 32'd1;
    end
  end
  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
`endif
endmodule

// File: tb/tb_bram_mem_initiator.sv
// tb_bram_mem_initiator: vector table plus random load/store traffic checked against a memory-image model.
module tb_bram_mem_initiator;
  logic        clock = 1'b0, reset;
  logic        req_valid, req_ready, req_write, resp_valid, resp_ready, bram_write_enable;
  logic [7:0]  req_address, bram_address;
  logic [3:0]  req_byte_en;
  logic [31:0] req_wdata, resp_rdata, bram_write_data, bram_read_data, stat_reads, stat_writes;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int total = 0, bad = 0, n_reads = 0, n_writes = 0, pulses = 0;
  logic [7:0]  pw_addr;
  logic [31:0] pw_data;

  bram_mem_initiator dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_address(req_address), .req_byte_en(req_byte_en),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .bram_write_enable(bram_write_enable),
    .bram_address(bram_address), .bram_write_data(bram_write_data),
    .bram_read_data(bram_read_data), .stat_reads(stat_reads), .stat_writes(stat_writes));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bram_write_enable) mem[bram_address] <= bram_write_data;
    bram_read_data <= mem[bram_address];
  end

  always @(negedge clock) if (bram_write_enable) begin
    pulses  = pulses + 1;
    pw_addr = bram_address;
    pw_data = bram_write_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic run(input logic w, input logic [7:0] a, input logic [3:0] be, input logic [31:0] wd,
                     input int hold, input logic [31:0] exp_rd, input int exp_lat, input int exp_pulse,
                     input logic [31:0] exp_wd);
    logic [31:0] rd0;
    int lat;
    logic stable;
    @(negedge clock);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = w; req_address = a; req_byte_en = be; req_wdata = wd; resp_ready = 0;
    pulses = 0;
    @(posedge clock); #1 req_valid = 0;
    if (w) n_writes++; else n_reads++;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    rd0 = resp_rdata;
    stable = 1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      if (!resp_valid || resp_rdata !== rd0 || req_ready) stable = 0;
    end
    if (hold > 0) chk("resp_hold_stable", stable, 1);
    chk("resp_rdata", rd0, exp_rd);
    @(negedge clock) resp_ready = 1;
    @(posedge clock); #1 resp_ready = 0;
    chk("resp_valid_drop", resp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    chk("write_pulses", pulses, exp_pulse);
    if (exp_pulse != 0) begin
      chk("write_addr", pw_addr, a);
      chk("write_data", pw_data, exp_wd);
      ref_mem[a] = exp_wd;
    end
  endtask

  task automatic chk_stats();
`ifdef BRAM_INIT_STATS_EN
    chk("stat_reads", stat_reads, n_reads);
    chk("stat_writes", stat_writes, n_writes);
`else
    chk("stat_reads_off", stat_reads, 0);
    chk("stat_writes_off", stat_writes, 0);
`endif
  endtask

  typedef struct {
    logic w; logic [7:0] a; logic [3:0] be; logic [31:0] wd; int hold;
    logic [31:0] rd; int lat; int p; logic [31:0] mwd;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic w;
    logic [7:0] a;
    logic [3:0] be;
    logic [31:0] wd, m;
    tbl[0]  = '{1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 0, 32'h0,        1, 1, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 8'h10, 4'h0, 32'h0,        0, 32'hDEADBEEF, 2, 0, 32'h0};
    tbl[2]  = '{1'b1, 8'h20, 4'hF, 32'h11223344, 0, 32'h0,        1, 1, 32'h11223344};
    tbl[3]  = '{1'b1, 8'h20, 4'h2, 32'h0000AA00, 0, 32'h0,        3, 1, 32'h1122AA44};
    tbl[4]  = '{1'b0, 8'h20, 4'h0, 32'h0,        0, 32'h1122AA44, 2, 0, 32'h0};
    tbl[5]  = '{1'b1, 8'h20, 4'h0, 32'hFFFFFFFF, 0, 32'h0,        1, 0, 32'h0};
    tbl[6]  = '{1'b0, 8'h20, 4'h0, 32'h0,        1, 32'h1122AA44, 2, 0, 32'h0};
    tbl[7]  = '{1'b1, 8'h30, 4'hF, 32'h0,        0, 32'h0,        1, 1, 32'h0};
    tbl[8]  = '{1'b1, 8'h30, 4'h9, 32'hAABBCCDD, 0, 32'h0,        3, 1, 32'hAA0000DD};
    tbl[9]  = '{1'b0, 8'h30, 4'h0, 32'h0,        5, 32'hAA0000DD, 2, 0, 32'h0};
    tbl[10] = '{1'b1, 8'h40, 4'hF, 32'h12345678, 0, 32'h0,        1, 1, 32'h12345678};
    tbl[11] = '{1'b0, 8'h10, 4'h0, 32'h0,        2, 32'hDEADBEEF, 2, 0, 32'h0};
    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      mem[i] <= wd;
      ref_mem[i] = wd;
    end
    reset = 1; req_valid = 0; req_write = 0; req_address = 0; req_byte_en = 0; req_wdata = 0; resp_ready = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_we", bram_write_enable, 0);
    chk("rst_addr", bram_address, 0);
    chk("rst_wdata", bram_write_data, 0);
    chk_stats();

    for (int i = 0; i < 12; i++)
      run(tbl[i].w, tbl[i].a, tbl[i].be, tbl[i].wd, tbl[i].hold, tbl[i].rd, tbl[i].lat, tbl[i].p, tbl[i].mwd);
    chk_stats();

    // Reset in the middle of the read-modify-write pulse must cancel the write.
    @(negedge clock);
    req_valid = 1; req_write = 1; req_address = 8'h40; req_byte_en = 4'h1; req_wdata = 32'hFF; resp_ready = 0;
    @(posedge clock); #1 req_valid = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("we_in_rmw_wr", bram_write_enable, 1);
    #2 reset = 1;
    #1 chk("we_async_drop", bram_write_enable, 0);
    @(negedge clock) reset = 0;
    n_reads = 0; n_writes = 0;
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_resp_valid", resp_valid, 0);
    chk_stats();
    run(0, 8'h40, 4'h0, 32'h0, 0, 32'h12345678, 2, 0, 32'h0);

    for (int n = 0; n < 150; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: be = 4'h0;
        1: be = 4'hF;
        default: be = 4'($urandom);
      endcase
      wd = $urandom;
      if (!w) run(0, a, be, wd, $urandom_range(0, 2), ref_mem[a], 2, 0, 32'h0);
      else begin
        for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? wd[8*b +: 8] : ref_mem[a][8*b +: 8];
        run(1, a, be, wd, $urandom_range(0, 2), 32'h0, (be == 4'h0 || be == 4'hF) ? 1 : 3,
            (be != 4'h0) ? 1 : 0, m);
      end
    end
    chk_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
